// File: rtl/ram_stream_sequencer_pkg.sv
// Shared types and default widths for the RAM fill/drain stream sequencer.
package ram_seq_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_e;

endpackage

// File: rtl/ram_stream_sequencer.sv
// Fills a single-port RAM from an input stream at addresses 0..len, then drains the same
// addresses as an output stream. state_q is the observable FSM state for bound checkers.
//
// Handshakes: a word moves on a rising edge where valid && ready are both high; a source
// holds valid and data stable until that edge, and ready may be asserted independently.
module ram_stream_sequencer
    import ram_seq_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    in_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        in_hs       = (state_q == FILL) && in_valid;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (in_hs) begin
                    if (cnt_q == len_q) begin
                        cnt_d   = '0;
                        state_d = RD_ADDR;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                // First RD_DATA cycle captures the RAM word; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    out_data_d  = ram_rdata;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == len_q);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == FILL);
    assign ram_we    = in_hs;
    assign ram_addr  = cnt_q;
    assign ram_wdata = in_hs ? in_data : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
